// File: rtl/id_decode_buf_pkg.sv
// Shared decode definitions: opcode map, opcode class masks, register-use
// helpers and the decoded-field record carried by the output register.
package id_decode_buf_pkg;

    localparam int OPC_W = 8;
    localparam int REG_W = 4;
    localparam int BCC_W = 4;

    localparam logic [OPC_W-1:0] OPC_NOP     = 8'h00;
    localparam logic [OPC_W-1:0] OPC_ADD     = 8'h01;
    localparam logic [OPC_W-1:0] OPC_ADDI    = 8'h02;
    localparam logic [OPC_W-1:0] OPC_ADDIS   = 8'h03;
    localparam logic [OPC_W-1:0] OPC_LD      = 8'h04;
    localparam logic [OPC_W-1:0] OPC_ST      = 8'h05;
    localparam logic [OPC_W-1:0] OPC_BCC     = 8'h06;
    localparam logic [OPC_W-1:0] OPC_MOV     = 8'h07;
    localparam logic [OPC_W-1:0] OPC_S_SRMOV = 8'h10;
    localparam logic [OPC_W-1:0] OPC_S_SRBCC = 8'h11;

    // One bit per opcode value; a set bit places the opcode in the class.
    localparam logic [255:0] IMM_CLASS_MASK =
        (256'd1 << OPC_ADDI) | (256'd1 << OPC_ADDIS) | (256'd1 << OPC_LD) |
        (256'd1 << OPC_ST)   | (256'd1 << OPC_BCC)   | (256'd1 << OPC_S_SRBCC);
    localparam logic [255:0] SGN_CLASS_MASK =
        (256'd1 << OPC_ADDIS) | (256'd1 << OPC_LD) | (256'd1 << OPC_ST) |
        (256'd1 << OPC_BCC)   | (256'd1 << OPC_S_SRBCC);

    typedef struct packed {
        logic [BCC_W-1:0] bcc;
        logic [REG_W-1:0] tgt_gp;
        logic [REG_W-1:0] src_gp;
        logic [REG_W-1:0] tgt_sr;
        logic [REG_W-1:0] src_sr;
        logic             imm_en;
        logic             sgn_en;
    } dec_fields_t;

    function automatic logic is_imm_fn(input logic [OPC_W-1:0] op);
        return IMM_CLASS_MASK[op];
    endfunction

    function automatic logic is_sgn_fn(input logic [OPC_W-1:0] op);
        return SGN_CLASS_MASK[op];
    endfunction

    function automatic logic is_special_fn(input logic [OPC_W-1:0] op);
        return (op == OPC_S_SRMOV) || (op == OPC_S_SRBCC);
    endfunction

    function automatic logic reg_src_read_fn(input logic [OPC_W-1:0] op);
        logic rd;
        case (op)
            OPC_ADD, OPC_MOV, OPC_LD, OPC_ST: rd = 1'b1;
            default:                          rd = 1'b0;
        endcase
        return rd;
    endfunction

    function automatic logic reg_tgt_read_fn(input logic [OPC_W-1:0] op);
        logic rd;
        case (op)
            OPC_ADD, OPC_ADDI, OPC_ADDIS,
            OPC_LD, OPC_ST, OPC_MOV:      rd = 1'b1;
            default:                      rd = 1'b0;
        endcase
        return rd;
    endfunction

endpackage

// File: rtl/id_decode_buf_skid_fifo.sv
// Small circular skid buffer holding {pc, instr} beats ahead of decode.
// Any DEPTH >= 1 is supported; pointers wrap explicitly at DEPTH-1.
module id_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_BITS-1:0] count_r;
    logic                push_ok_s;
    logic                pop_ok_s;

    function automatic logic [PTR_W-1:0] next_ptr_fn(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == '0);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign rdata     = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; flush empties the buffer in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= next_ptr_fn(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= next_ptr_fn(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_BITS'(1);
                2'b01:   count_r <= count_r - CNT_BITS'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/id_decode_buf.sv
// Instruction-decode stage: skid FIFO in front, combinational decode of the
// FIFO head, and a registered output record with stall bubbles and flush.
module id_decode_buf
    import id_decode_buf_pkg::*;
#(
    parameter int PC_W    = 24,
    parameter int INSTR_W = 24,
    parameter int DATA_W  = 24,
    parameter int IMM_W   = 12,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_in,
    output logic               enable_out,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               stall_in,
    input  logic               flush_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [3:0]         bcc_out,
    output logic [3:0]         tgt_gp_out,
    output logic [3:0]         src_gp_out,
    output logic [3:0]         tgt_sr_out,
    output logic [3:0]         src_sr_out,
    output logic               imm_en_out,
    output logic               sgn_en_out,
    output logic [DATA_W-1:0]  imm_val_out,
    output logic [CNT_W-1:0]   bubble_cnt_out
);

    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                fifo_flush_s;
    logic                push_s;
    logic                pop_s;
    logic                load_s;
    logic [PC_W+INSTR_W-1:0] head_s;
    logic [PC_W-1:0]     head_pc_s;
    logic [INSTR_W-1:0]  head_instr_s;

    logic [INSTR_W-1:0]  dec_instr_s;
    logic [OPC_W-1:0]    dec_op_s;
    dec_fields_t         dec_s;
    logic [IMM_W-1:0]    imm_raw_s;
    logic [DATA_W-1:0]   imm_val_s;

    logic                out_valid_r;
    logic [PC_W-1:0]     pc_r;
    logic [INSTR_W-1:0]  instr_r;
    dec_fields_t         fields_r;
    logic [DATA_W-1:0]   imm_val_r;
    logic [CNT_W-1:0]    bubble_cnt_r;

    // in_ready looks only at enable and FIFO occupancy, never at out_ready.
    assign enable_out   = enable_in;
    assign in_ready     = enable_in && !fifo_full_s;
    assign push_s       = in_valid && in_ready && !flush_in;
    assign load_s       = (!out_valid_r || out_ready) && !flush_in;
    assign pop_s        = enable_in && load_s && !stall_in && !fifo_empty_s;
    assign fifo_flush_s = enable_in && flush_in;
    assign head_pc_s    = head_s[PC_W+INSTR_W-1 -: PC_W];
    assign head_instr_s = head_s[INSTR_W-1:0];

    id_skid_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush_s),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({in_pc, in_instr}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Decode of the FIFO head; a NOP is squashed to an all-zero instruction.
    always_comb begin
        dec_s = '0;
        if (head_instr_s[INSTR_W-1 -: OPC_W] == OPC_NOP) begin
            dec_instr_s = '0;
        end else begin
            dec_instr_s = head_instr_s;
        end
        dec_op_s   = dec_instr_s[INSTR_W-1 -: OPC_W];
        dec_s.bcc  = dec_instr_s[15:12];
        if (is_special_fn(dec_op_s)) begin
            dec_s.tgt_sr = dec_instr_s[7:4];
            dec_s.src_sr = dec_instr_s[3:0];
        end else begin
            dec_s.tgt_gp = reg_tgt_read_fn(dec_op_s) ? dec_instr_s[7:4] : 4'h0;
            dec_s.src_gp = reg_src_read_fn(dec_op_s) ? dec_instr_s[3:0] : 4'h0;
        end
        dec_s.imm_en = is_imm_fn(dec_op_s);
        dec_s.sgn_en = is_sgn_fn(dec_op_s);
        imm_raw_s    = dec_instr_s[IMM_W-1:0];
        if (dec_s.sgn_en && dec_s.imm_en) begin
            imm_val_s = DATA_W'($signed(imm_raw_s));
        end else begin
            imm_val_s = DATA_W'(imm_raw_s);
        end
    end

    // Output record register and saturating bubble counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            pc_r         <= '0;
            instr_r      <= '0;
            fields_r     <= '0;
            imm_val_r    <= '0;
            bubble_cnt_r <= '0;
        end else if (enable_in) begin
            if (flush_in) begin
                out_valid_r <= 1'b0;
                pc_r        <= '0;
                instr_r     <= '0;
                fields_r    <= '0;
                imm_val_r   <= '0;
            end else if (load_s) begin
                if (stall_in) begin
                    // Bubble: head stays in the FIFO, PC tracks it when present.
                    out_valid_r <= 1'b1;
                    instr_r     <= '0;
                    fields_r    <= '0;
                    imm_val_r   <= '0;
                    if (!fifo_empty_s) begin
                        pc_r <= head_pc_s;
                    end
                    if (bubble_cnt_r != '1) begin
                        bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
                    end
                end else if (!fifo_empty_s) begin
                    out_valid_r <= 1'b1;
                    pc_r        <= head_pc_s;
                    instr_r     <= dec_instr_s;
                    fields_r    <= dec_s;
                    imm_val_r   <= imm_val_s;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end
        end
    end

    assign out_valid      = out_valid_r;
    assign pc_out         = pc_r;
    assign instr_out      = instr_r;
    assign bcc_out        = fields_r.bcc;
    assign tgt_gp_out     = fields_r.tgt_gp;
    assign src_gp_out     = fields_r.src_gp;
    assign tgt_sr_out     = fields_r.tgt_sr;
    assign src_sr_out     = fields_r.src_sr;
    assign imm_en_out     = fields_r.imm_en;
    assign sgn_en_out     = fields_r.sgn_en;
    assign imm_val_out    = imm_val_r;
    assign bubble_cnt_out = bubble_cnt_r;

endmodule

// File: tb/tb_id_decode_buf.sv
// Directed bench for id_decode_buf (DEPTH=2, CNT_W=4): decode, back-pressure,
// stall bubbles, flush, enable gating, counter saturation and async reset.
module tb_id_decode_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_in;
    logic        enable_out;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_pc;
    logic [23:0] in_instr;
    logic        stall_in;
    logic        flush_in;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] pc_out;
    logic [23:0] instr_out;
    logic [3:0]  bcc_out;
    logic [3:0]  tgt_gp_out;
    logic [3:0]  src_gp_out;
    logic [3:0]  tgt_sr_out;
    logic [3:0]  src_sr_out;
    logic        imm_en_out;
    logic        sgn_en_out;
    logic [23:0] imm_val_out;
    logic [3:0]  bubble_cnt_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_decode_buf #(
        .PC_W(24), .INSTR_W(24), .DATA_W(24), .IMM_W(12), .DEPTH(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .enable_in(enable_in), .enable_out(enable_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .stall_in(stall_in), .flush_in(flush_in), .out_valid(out_valid),
        .out_ready(out_ready), .pc_out(pc_out), .instr_out(instr_out),
        .bcc_out(bcc_out), .tgt_gp_out(tgt_gp_out), .src_gp_out(src_gp_out),
        .tgt_sr_out(tgt_sr_out), .src_sr_out(src_sr_out), .imm_en_out(imm_en_out),
        .sgn_en_out(sgn_en_out), .imm_val_out(imm_val_out),
        .bubble_cnt_out(bubble_cnt_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; enable_in = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        stall_in = 1'b0; flush_in = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_instr", 32'(instr_out), 32'h0);
        chk("rst_bubble", 32'(bubble_cnt_out), 32'h0);
        rst = 1'b0;
        tick();

        // ADDi: imm 0xF3F, tgt field [7:4]=3 lies inside the immediate.
        in_valid = 1'b1; in_pc = 24'h000010; in_instr = 24'h020F3F;
        tick();
        chk("lat_not_yet", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        tick();
        chk("addi_valid", 32'(out_valid), 32'h1);
        chk("addi_pc", 32'(pc_out), 32'h000010);
        chk("addi_instr", 32'(instr_out), 32'h020F3F);
        chk("addi_tgt_gp", 32'(tgt_gp_out), 32'h3);
        chk("addi_src_gp", 32'(src_gp_out), 32'h0);
        chk("addi_imm_en", 32'(imm_en_out), 32'h1);
        chk("addi_sgn_en", 32'(sgn_en_out), 32'h0);
        chk("addi_imm_val", 32'(imm_val_out), 32'h000F3F);

        // ADDis with imm 0x800 sign-extends; bcc field = 0xA.
        in_valid = 1'b1; in_pc = 24'h000014; in_instr = 24'h03A800;
        tick(); in_valid = 1'b0; tick();
        chk("addis_imm_val", 32'(imm_val_out), 32'hFFF800);
        chk("addis_sgn_en", 32'(sgn_en_out), 32'h1);
        chk("addis_bcc", 32'(bcc_out), 32'hA);

        // SRMOV 0x52 -> special regs only.
        in_valid = 1'b1; in_pc = 24'h000030; in_instr = 24'h100052;
        tick(); in_valid = 1'b0; tick();
        chk("srmov_tgt_sr", 32'(tgt_sr_out), 32'h5);
        chk("srmov_src_sr", 32'(src_sr_out), 32'h2);
        chk("srmov_gp", 32'({tgt_gp_out, src_gp_out}), 32'h0);
        chk("srmov_imm_val", 32'(imm_val_out), 32'h000052);

        // NOP with junk payload is squashed to zero.
        in_valid = 1'b1; in_pc = 24'h000034; in_instr = 24'h005123;
        tick(); in_valid = 1'b0; tick();
        chk("nop_valid", 32'(out_valid), 32'h1);
        chk("nop_instr", 32'(instr_out), 32'h0);
        chk("nop_fields", 32'({bcc_out, imm_val_out}), 32'h0);
        tick();
        chk("drain_empty", 32'(out_valid), 32'h0);

        // Back-pressure: 3 beats with out_ready low fill 2 + 1 held.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 24'h000040; in_instr = 24'h010034;
        tick();
        in_pc = 24'h000044; in_instr = 24'h070056;
        tick();
        chk("bp_ready_1", 32'(in_ready), 32'h1);
        in_pc = 24'h000048; in_instr = 24'h040F8F;
        tick();
        in_valid = 1'b0;
        chk("bp_full_ready", 32'(in_ready), 32'h0);
        chk("bp_held_pc", 32'(pc_out), 32'h000040);
        tick();
        chk("bp_stable_pc", 32'(pc_out), 32'h000040);
        chk("bp_add_regs", 32'({tgt_gp_out, src_gp_out}), 32'h34);
        out_ready = 1'b1;
        tick();
        chk("bp_rec2_pc", 32'(pc_out), 32'h000044);
        chk("bp_mov_regs", 32'({tgt_gp_out, src_gp_out, 3'b000, imm_en_out}), 32'h560);
        chk("bp_ready_back", 32'(in_ready), 32'h1);
        tick();
        chk("bp_rec3_pc", 32'(pc_out), 32'h000048);
        chk("bp_ld_imm", 32'(imm_val_out), 32'hFFFF8F);
        chk("bp_ld_regs", 32'({tgt_gp_out, src_gp_out}), 32'h8F);
        tick();
        chk("bp_done", 32'(out_valid), 32'h0);

        // Stall: two bubbles carrying head pc 0x20, then the real record.
        in_valid = 1'b1; in_pc = 24'h000020; in_instr = 24'h020012;
        tick();
        in_valid = 1'b0; stall_in = 1'b1;
        tick();
        chk("stall_b1_valid", 32'(out_valid), 32'h1);
        chk("stall_b1_instr", 32'(instr_out), 32'h0);
        chk("stall_b1_pc", 32'(pc_out), 32'h000020);
        tick();
        chk("stall_b2_cnt", 32'(bubble_cnt_out), 32'h2);
        chk("stall_b2_fields", 32'({tgt_gp_out, imm_val_out}), 32'h0);
        stall_in = 1'b0;
        tick();
        chk("stall_real_instr", 32'(instr_out), 32'h020012);
        chk("stall_real_pc", 32'(pc_out), 32'h000020);
        chk("stall_real_tgt", 32'(tgt_gp_out), 32'h1);

        // Flush with FIFO full and a held record; flush-cycle beat dropped.
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 24'h000050; in_instr = 24'h010011;
        tick();
        in_pc = 24'h000054; in_instr = 24'h010022;
        tick();
        chk("fl_full", 32'(in_ready), 32'h0);
        flush_in = 1'b1; in_pc = 24'h000058; in_instr = 24'h010033;
        tick();
        flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_valid", 32'(out_valid), 32'h0);
        chk("fl_ready", 32'(in_ready), 32'h1);
        chk("fl_zero", 32'({pc_out, instr_out[7:0]}), 32'h0);
        chk("fl_bubble_kept", 32'(bubble_cnt_out), 32'h2);
        tick();
        chk("fl_no_beat", 32'(out_valid), 32'h0);

        // Enable gating: buffered beat not loaded, new beat not pushed.
        in_valid = 1'b1; in_pc = 24'h000060; in_instr = 24'h020070;
        tick();
        enable_in = 1'b0; in_pc = 24'h000064;
        #1;
        chk("en_in_ready", 32'(in_ready), 32'h0);
        chk("en_out", 32'(enable_out), 32'h0);
        tick(); tick();
        chk("en_frozen", 32'(out_valid), 32'h0);
        enable_in = 1'b1; in_valid = 1'b0;
        tick();
        chk("en_resume_pc", 32'(pc_out), 32'h000060);
        tick();
        chk("en_no_push", 32'(out_valid), 32'h0);

        // Saturation: 16 more bubbles from 2 pins the 4-bit counter at 0xF.
        stall_in = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("sat_cnt", 32'(bubble_cnt_out), 32'hF);
        chk("sat_pc_kept", 32'(pc_out), 32'h000060);
        tick();
        chk("sat_hold", 32'(bubble_cnt_out), 32'hF);
        stall_in = 1'b0;

        // Asynchronous reset mid-operation.
        in_valid = 1'b1; in_pc = 24'h000070; in_instr = 24'h020001;
        tick(); tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_cnt", 32'(bubble_cnt_out), 32'h0);
        chk("arst_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;
        tick(); tick();
        chk("arst_no_survivor", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
